iomem_burst_master: RTL and testbench

- Initiator on the picosoc iomem bus; the counterpart of the iomem responders such as the video peripheral.
- Takes one command per burst and issues word accesses at consecutive addresses over an iomem master port.
- Write mode fills memory with a linear pattern, e.g. tile or texture memory at boot or on level change.
- Read mode sums the words it reads back, giving a checksum of a region.
- Sits between a CPU-side command register block and the iomem interconnect.

---
 rtl/iomem_burst_master_if.sv | 28 ++
 rtl/iomem_burst_master.sv | 168 ++++++++++++++++
 tb/tb_iomem_burst_master.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iomem_burst_master_if.sv
// iomem bus bundle between a burst initiator (master) and a responder (slave).
// Read data is only meaningful while iomem_ready is high.
interface iomem_burst_master_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (
      output iomem_valid,
      output iomem_wstrb,
      output iomem_addr,
      output iomem_wdata,
      input  iomem_ready,
      input  iomem_rdata
   );

   modport slave (
      input  iomem_valid,
      input  iomem_wstrb,
      input  iomem_addr,
      input  iomem_wdata,
      output iomem_ready,
      output iomem_rdata
   );
endinterface

// File: rtl/iomem_burst_master.sv
// iomem burst initiator: linear-pattern fill (write) or checksum (read) of consecutive words.
// Optional per-beat ready timeout is compiled in with `define IOMEM_BURST_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | cmd_ready high, waiting for a command
// S_BURST | iomem_valid high, issuing beats until the last one completes
// S_FIN   | one-cycle done pulse, then back to S_IDLE
module iomem_burst_master #(
   parameter int ADDR_STRIDE    = 4,
   parameter int COUNT_W        = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_read,
   input  logic [31:0]         cmd_addr,
   input  logic [COUNT_W-1:0]  cmd_count,
   input  logic [31:0]         cmd_data,
   input  logic [31:0]         cmd_step,
   input  logic [3:0]          cmd_wstrb,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [31:0]         result,
   iomem_burst_master_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_FIN   = 2'd2
   } state_t;

   state_t             state;
   logic               read_q;
   logic [31:0]        step_q;
   logic [COUNT_W-1:0] beats_left;
   logic               valid_q;
   logic [3:0]         wstrb_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic               cmd_ready_q;
   logic               busy_q;
   logic               done_q;
   logic [31:0]        result_q;

`ifdef IOMEM_BURST_TIMEOUT_EN
   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   // Down-counter per beat; terminal count 0 means TIMEOUT_CYCLES cycles without ready.
   logic [TMR_W-1:0] tmr;
   logic             error_q;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         read_q      <= 1'b0;
         step_q      <= '0;
         beats_left  <= '0;
         valid_q     <= 1'b0;
         wstrb_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= '0;
`ifdef IOMEM_BURST_TIMEOUT_EN
         tmr         <= '0;
         error_q     <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  read_q      <= cmd_read;
                  step_q      <= cmd_step;
                  beats_left  <= cmd_count;
                  addr_q      <= cmd_addr;
                  wdata_q     <= cmd_data;
                  wstrb_q     <= cmd_read ? 4'h0 : cmd_wstrb;
                  result_q    <= '0;
                  cmd_ready_q <= 1'b0;
`ifdef IOMEM_BURST_TIMEOUT_EN
                  tmr         <= TMR_LOAD;
                  error_q     <= 1'b0;
`endif
                  if (cmd_count == '0) begin
                     state  <= S_FIN;
                     done_q <= 1'b1;
                  end else begin
                     state   <= S_BURST;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b1;
                  end
               end
            end

            S_BURST: begin
               if (bus.iomem_ready) begin
                  result_q <= read_q ? (result_q + bus.iomem_rdata) : (result_q + 32'd1);
                  if (beats_left == COUNT_W'(1)) begin
                     state   <= S_FIN;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     // valid stays high: the responder drops ready before acking the next beat
                     beats_left <= beats_left - COUNT_W'(1);
                     addr_q     <= addr_q + 32'(ADDR_STRIDE);
                     wdata_q    <= wdata_q + step_q;
`ifdef IOMEM_BURST_TIMEOUT_EN
                     tmr        <= TMR_LOAD;
`endif
                  end
               end
`ifdef IOMEM_BURST_TIMEOUT_EN
               else if (tmr == '0) begin
                  state   <= S_FIN;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  error_q <= 1'b1;
               end else begin
                  tmr <= tmr - 1'b1;
               end
`endif
            end

            S_FIN: begin
               state       <= S_IDLE;
               done_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end

            default: begin
               state       <= S_IDLE;
               valid_q     <= 1'b0;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready       = cmd_ready_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign result          = result_q;
   assign bus.iomem_valid = valid_q;
   assign bus.iomem_wstrb = wstrb_q;
   assign bus.iomem_addr  = addr_q;
   assign bus.iomem_wdata = wdata_q;

`ifdef IOMEM_BURST_TIMEOUT_EN
   assign error = error_q;
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT_CYCLES;
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_burst_master.sv
// Randomized self-checking bench for iomem_burst_master with a latency-programmable responder.
// Expected beats/results come from arithmetic over the command fields and the supplied read data.
module tb_iomem_burst_master;
   localparam int TO_CYC = 8;

   logic        clk;
   logic        resetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_read;
   logic [31:0] cmd_addr;
   logic [15:0] cmd_count;
   logic [31:0] cmd_data;
   logic [31:0] cmd_step;
   logic [3:0]  cmd_wstrb;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   iomem_burst_master_if bus ();

   iomem_burst_master #(
      .ADDR_STRIDE   (4),
      .COUNT_W       (16),
      .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_read (cmd_read),
      .cmd_addr (cmd_addr),
      .cmd_count(cmd_count),
      .cmd_data (cmd_data),
      .cmd_step (cmd_step),
      .cmd_wstrb(cmd_wstrb),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .result   (result),
      .bus      (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // responder programming and observations
   int          lat_q[$];
   logic [31:0] rdq[$];
   logic [31:0] obs_addr[$];
   logic [31:0] obs_wdata[$];
   logic [3:0]  obs_wstrb[$];
   int  done_cnt = 0, gap_cnt = 0, unstable_cnt = 0, hi_run = 0, last_run = 0;
   bit  beat_done_flag = 0, p_valid = 0;
   logic [31:0] p_addr = '0, p_wdata = '0;
   logic [3:0]  p_wstrb = '0;

   // responder: ready for one cycle after a per-beat latency, never twice without seeing it low
   initial begin
      int  wait_cnt, cur_lat;
      bit  have_lat;
      wait_cnt = 0; cur_lat = 0; have_lat = 0;
      bus.iomem_ready = 1'b0;
      bus.iomem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            bus.iomem_ready = 1'b0;
            have_lat = 0;
            wait_cnt = 0;
         end else if (bus.iomem_ready) begin
            bus.iomem_ready = 1'b0;
         end else if (bus.iomem_valid) begin
            if (!have_lat) begin
               cur_lat  = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
               have_lat = 1;
               wait_cnt = 0;
            end
            if (wait_cnt >= cur_lat) begin
               bus.iomem_ready = 1'b1;
               bus.iomem_rdata = (rdq.size() != 0) ? rdq.pop_front() : $urandom;
               have_lat = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            have_lat = 0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         beat_done_flag = 0;
         if (resetn && bus.iomem_valid && bus.iomem_ready) begin
            obs_addr.push_back(bus.iomem_addr);
            obs_wdata.push_back(bus.iomem_wdata);
            obs_wstrb.push_back(bus.iomem_wstrb);
            beat_done_flag = 1;
            hi_run = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (resetn) begin
            if (done) done_cnt++;
            if (busy && !bus.iomem_valid) gap_cnt++;
            if (bus.iomem_valid && p_valid && !beat_done_flag &&
                (bus.iomem_addr !== p_addr || bus.iomem_wdata !== p_wdata || bus.iomem_wstrb !== p_wstrb))
               unstable_cnt++;
            if (bus.iomem_valid) hi_run++;
            else if (hi_run != 0) begin
               last_run = hi_run;
               hi_run   = 0;
            end
         end
         p_valid = bus.iomem_valid;
         p_addr  = bus.iomem_addr;
         p_wdata = bus.iomem_wdata;
         p_wstrb = bus.iomem_wstrb;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_obs();
      obs_addr.delete();
      obs_wdata.delete();
      obs_wstrb.delete();
      done_cnt = 0; gap_cnt = 0; unstable_cnt = 0; hi_run = 0; last_run = 0;
   endtask

   // Issue one command, scramble the command inputs afterwards, wait for done plus one cycle.
   task automatic run_burst(input bit rd, input logic [31:0] a, input logic [15:0] n,
                            input logic [31:0] d, input logic [31:0] s, input logic [3:0] st,
                            input int max_cyc, output bit timed_out);
      int k;
      clear_obs();
      k = 0;
      @(negedge clk);
      while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
      cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_count = n;
      cmd_data = d; cmd_step = s; cmd_wstrb = st;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_read = ~rd; cmd_addr = $urandom; cmd_count = 16'($urandom);
      cmd_data = $urandom; cmd_step = $urandom; cmd_wstrb = 4'($urandom);
      k = 0;
      while (!done && k < max_cyc) begin @(negedge clk); k++; end
      timed_out = !done;
      @(negedge clk);
   endtask

   task automatic test_reset();
      resetn = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_count = '0;
      cmd_data = '0; cmd_step = '0; cmd_wstrb = '0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
      n_checks++; if (bus.iomem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.iomem_valid); end
      n_checks++; if ({bus.iomem_addr, bus.iomem_wdata, bus.iomem_wstrb} !== 68'h0) begin
         n_fail++; $display("FAIL reset_bus: got addr %h wdata %h wstrb %h expected all 0", bus.iomem_addr, bus.iomem_wdata, bus.iomem_wstrb);
      end
   endtask

   task automatic test_write_fill();
      bit to;
      lat_q = {1, 1, 1, 1};
      run_burst(1'b0, 32'h0200_0000, 16'd4, 32'h10, 32'h1, 4'hF, 200, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL fill_timeout: done never seen"); end
      n_checks++; if (obs_addr.size() != 4) begin n_fail++; $display("FAIL fill_beats: got %0d expected 4", obs_addr.size()); end
      for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
         n_checks++; if (obs_addr[i] !== 32'h0200_0000 + 32'(i) * 32'd4) begin
            n_fail++; $display("FAIL fill_addr[%0d]: got %h expected %h", i, obs_addr[i], 32'h0200_0000 + 32'(i) * 32'd4); end
         n_checks++; if (obs_wdata[i] !== 32'h10 + 32'(i)) begin
            n_fail++; $display("FAIL fill_wdata[%0d]: got %h expected %h", i, obs_wdata[i], 32'h10 + 32'(i)); end
         n_checks++; if (obs_wstrb[i] !== 4'hF) begin
            n_fail++; $display("FAIL fill_wstrb[%0d]: got %h expected f", i, obs_wstrb[i]); end
      end
      n_checks++; if (gap_cnt != 0) begin n_fail++; $display("FAIL fill_valid_gap: got %0d gap cycles expected 0", gap_cnt); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL fill_done_pulses: got %0d expected 1", done_cnt); end
      n_checks++; if (result !== 32'd4) begin n_fail++; $display("FAIL fill_result: got %h expected 4", result); end
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL fill_error: got %b expected 0", error); end
   endtask

   task automatic test_read_sum();
      bit to;
      lat_q = {0, 2, 1};
      rdq   = {32'h1, 32'hFFFF_FFFF, 32'h5};
      run_burst(1'b1, 32'h0300_0010, 16'd3, 32'h0, 32'h0, 4'hF, 200, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL sum_timeout: done never seen"); end
      n_checks++; if (obs_addr.size() != 3) begin n_fail++; $display("FAIL sum_beats: got %0d expected 3", obs_addr.size()); end
      for (int i = 0; i < obs_wstrb.size(); i++) begin
         n_checks++; if (obs_wstrb[i] !== 4'h0) begin n_fail++; $display("FAIL sum_wstrb[%0d]: got %h expected 0", i, obs_wstrb[i]); end
      end
      n_checks++; if (result !== 32'h5) begin n_fail++; $display("FAIL sum_result: got %h expected 00000005", result); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL sum_done_pulses: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_zero_count();
      clear_obs();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 32'h1234_0000; cmd_count = 16'd0;
      cmd_data = 32'hAA; cmd_step = 32'h1; cmd_wstrb = 4'hF;
      @(negedge clk);
      cmd_valid = 1'b0;
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", done); end
      n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL zero_cmd_ready_fin: got %b expected 0", cmd_ready); end
      n_checks++; if (bus.iomem_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid: got %b expected 0", bus.iomem_valid); end
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL zero_result: got %h expected 0", result); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b expected 0", done); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL zero_cmd_ready_idle: got %b expected 1", cmd_ready); end
      n_checks++; if (obs_addr.size() != 0) begin n_fail++; $display("FAIL zero_beats: got %0d expected 0", obs_addr.size()); end
   endtask

   task automatic test_wrap_stall();
      bit to;
      logic [31:0] d, s;
      d = $urandom; s = $urandom;
      lat_q = {5, 0};
      run_burst(1'b0, 32'hFFFF_FFFC, 16'd2, d, s, 4'h3, 200, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL wrap_timeout: done never seen"); end
      n_checks++; if (obs_addr.size() != 2) begin n_fail++; $display("FAIL wrap_beats: got %0d expected 2", obs_addr.size()); end
      if (obs_addr.size() == 2) begin
         n_checks++; if (obs_addr[0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h expected fffffffc", obs_addr[0]); end
         n_checks++; if (obs_addr[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1: got %h expected 00000000", obs_addr[1]); end
         n_checks++; if (obs_wdata[1] !== d + s) begin n_fail++; $display("FAIL wrap_wdata1: got %h expected %h", obs_wdata[1], d + s); end
      end
      n_checks++; if (unstable_cnt != 0) begin n_fail++; $display("FAIL wrap_stall_stable: got %0d changes expected 0", unstable_cnt); end
   endtask

   task automatic test_random();
      bit          to, rd;
      logic [31:0] a, d, s, rsum, v, exp_res;
      logic [3:0]  st;
      int          n;
      for (int it = 0; it < 10; it++) begin
         rd = 1'($urandom); a = $urandom & 32'hFFFF_FFFC; d = $urandom; s = $urandom;
         st = 4'($urandom); n = $urandom_range(0, 6);
         rsum = '0;
         for (int b = 0; b < n; b++) begin
            lat_q.push_back($urandom_range(0, 3));
            v = $urandom; rdq.push_back(v); rsum = rsum + v;
         end
         exp_res = rd ? rsum : 32'(n);
         run_burst(rd, a, 16'(n), d, s, st, 300, to);
         rdq.delete(); lat_q.delete();
         n_checks++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout: done never seen", it); end
         n_checks++; if (result !== exp_res) begin n_fail++; $display("FAIL rand%0d_result: got %h expected %h", it, result, exp_res); end
         n_checks++; if (obs_addr.size() != n) begin n_fail++; $display("FAIL rand%0d_beats: got %0d expected %0d", it, obs_addr.size(), n); end
         n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done_pulses: got %0d expected 1", it, done_cnt); end
         n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rand%0d_error: got %b expected 0", it, error); end
         for (int i = 0; i < n && i < obs_addr.size(); i++) begin
            n_checks++; if (obs_addr[i] !== a + 32'(i) * 32'd4 || obs_wdata[i] !== d + 32'(i) * s ||
                            obs_wstrb[i] !== (rd ? 4'h0 : st)) begin
               n_fail++;
               $display("FAIL rand%0d_beat%0d: got addr %h wdata %h wstrb %h expected %h %h %h", it, i,
                        obs_addr[i], obs_wdata[i], obs_wstrb[i], a + 32'(i) * 32'd4, d + 32'(i) * s, rd ? 4'h0 : st);
            end
         end
         n_checks++; if (unstable_cnt != 0) begin n_fail++; $display("FAIL rand%0d_stable: got %0d changes expected 0", it, unstable_cnt); end
      end
   endtask

   task automatic test_async_reset();
      bit to;
      int k;
      clear_obs();
      lat_q = {1, 1, 1, 1};
      @(negedge clk);
      cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 32'h0400_0000; cmd_count = 16'd4;
      cmd_data = 32'h100; cmd_step = 32'h4; cmd_wstrb = 4'hF;
      @(negedge clk);
      cmd_valid = 1'b0;
      k = 0;
      while (obs_addr.size() < 2 && k < 100) begin @(negedge clk); k++; end
      n_checks++; if (obs_addr.size() != 2) begin n_fail++; $display("FAIL arst_reach_beat2: got %0d beats expected 2", obs_addr.size()); end
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      n_checks++; if (bus.iomem_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", bus.iomem_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL arst_done: got %b expected 0", done); end
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL arst_result: got %h expected 0", result); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL arst_cmd_ready: got %b expected 1", cmd_ready); end
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      lat_q.delete(); rdq.delete();
      lat_q = {0, 1};
      run_burst(1'b0, 32'h0500_0000, 16'd2, 32'h7, 32'h3, 4'h1, 200, to);
      n_checks++; if (to || result !== 32'd2) begin n_fail++; $display("FAIL arst_after_result: got %h expected 2", result); end
      n_checks++; if (obs_addr.size() != 2 || obs_addr[obs_addr.size()-1] !== 32'h0500_0004) begin
         n_fail++; $display("FAIL arst_after_beats: got %0d beats expected 2 ending at 05000004", obs_addr.size()); end
   endtask

`ifdef IOMEM_BURST_TIMEOUT_EN
   task automatic test_timeout();
      bit to;
      lat_q = {0, 1_000_000};
      run_burst(1'b0, 32'h0600_0000, 16'd3, 32'h1, 32'h1, 4'hF, 200, to);
      lat_q.delete();
      n_checks++; if (to) begin n_fail++; $display("FAIL tmo_done: done never seen"); end
      n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL tmo_error: got %b expected 1", error); end
      n_checks++; if (result !== 32'd1) begin n_fail++; $display("FAIL tmo_result: got %h expected 1", result); end
      n_checks++; if (last_run != TO_CYC) begin n_fail++; $display("FAIL tmo_valid_cycles: got %0d expected %0d", last_run, TO_CYC); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL tmo_done_pulses: got %0d expected 1", done_cnt); end
      lat_q = {0};
      run_burst(1'b0, 32'h0600_0000, 16'd1, 32'h1, 32'h1, 4'hF, 200, to);
      n_checks++; if (error !== 1'b0 || result !== 32'd1) begin
         n_fail++; $display("FAIL tmo_clear: got error %b result %h expected 0 and 1", error, result); end
   endtask
`endif

   initial begin
      test_reset();
      test_write_fill();
      test_read_sum();
      test_zero_count();
      test_wrap_stall();
      test_random();
      test_async_reset();
`ifdef IOMEM_BURST_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
